// File: rtl/uart_bitvec_bridge_pkg.sv
// rtl/uart_bitvec_bridge_pkg.sv - shared states, character constants and hex helper for the bit-vector bridge
package bitvec_bridge_pkg;

  typedef enum logic [2:0] {
    SNAP,
    BITS,
    CSUM_HI,
    CSUM_LO,
    TERM
  } state_e;

  localparam logic [7:0] DEFAULT_TERM_CHAR = 8'h2A;
  localparam logic [7:0] DEFAULT_ZERO_CHAR = 8'h30;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'd0, nibble};
    end
    return 8'h37 + {4'd0, nibble};
  endfunction

endpackage

// File: rtl/uart_bitvec_bridge_if.sv
// rtl/uart_bitvec_bridge_if.sv - usb_uart byte-stream pair (uart_out -> rx, tx -> uart_in)
interface uart_bitvec_bridge_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_bitvec_bridge_tx.sv
// rtl/uart_bitvec_bridge_tx.sv - snapshot-and-serialise FSM; BITVEC_BRIDGE_CHECKSUM_EN adds a hex checksum
module bitvec_tx_serializer
  import bitvec_bridge_pkg::*;
#(
  parameter int         OUT_LEN   = 64,
  parameter logic [7:0] TERM_CHAR = DEFAULT_TERM_CHAR,
  parameter logic [7:0] ZERO_CHAR = DEFAULT_ZERO_CHAR
) (
  input  logic               clk_48mhz,
  input  logic               reset,
  input  logic [OUT_LEN-1:0] out_vec,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic [15:0]        frame_count
);

  localparam int IDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LEN - 1);

  state_e             state_q, state_d;
  logic [OUT_LEN-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_next;
  logic               next_bit;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               xfer;
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  function automatic logic [7:0] bit_char(input logic b);
    return ZERO_CHAR + {7'd0, b};
  endfunction

  assign xfer     = tx_valid_q && tx_ready;
  assign idx_next = idx_q + IDX_W'(1);

  always_comb begin
    next_bit = 1'b0;
    for (int i = 0; i < OUT_LEN; i++) begin
      if (idx_next == IDX_W'(i)) next_bit = shadow_q[i];
    end
  end

  // tx_data/tx_valid are registered, so each branch prepares the byte presented next cycle
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    idx_d         = idx_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    frame_count_d = frame_count_q;
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      SNAP: begin
        shadow_d   = out_vec;
        idx_d      = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = bit_char(out_vec[0]);
        state_d    = BITS;
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
        sum_d      = 8'd0;
`endif
      end
      BITS: begin
        if (xfer) begin
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
          sum_d = sum_q + tx_data_q;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d     = idx_next;
            tx_data_d = bit_char(next_bit);
          end else begin
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
            state_d   = CSUM_HI;
            tx_data_d = hex_ascii(sum_d[7:4]);
`else
            state_d   = TERM;
            tx_data_d = TERM_CHAR;
`endif
          end
        end
      end
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
      CSUM_HI: begin
        if (xfer) begin
          state_d   = CSUM_LO;
          tx_data_d = hex_ascii(sum_q[3:0]);
        end
      end
      CSUM_LO: begin
        if (xfer) begin
          state_d   = TERM;
          tx_data_d = TERM_CHAR;
        end
      end
`endif
      TERM: begin
        if (xfer) begin
          frame_count_d = frame_count_q + 16'd1;
          tx_valid_d    = 1'b0;
          state_d       = SNAP;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = SNAP;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state_q       <= SNAP;
      shadow_q      <= '0;
      idx_q         <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      frame_count_q <= 16'd0;
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
      sum_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      frame_count_q <= frame_count_d;
`ifdef BITVEC_BRIDGE_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign frame_count = frame_count_q;

endmodule

// File: rtl/uart_bitvec_bridge.sv
// rtl/uart_bitvec_bridge.sv - usb_uart byte stream to core bit-vector bridge; BITVEC_BRIDGE_CHECKSUM_EN selects checksummed frames
module uart_bitvec_bridge
  import bitvec_bridge_pkg::*;
#(
  parameter int         IN_LEN    = 64,
  parameter int         OUT_LEN   = 64,
  parameter logic [7:0] TERM_CHAR = DEFAULT_TERM_CHAR,
  parameter logic [7:0] ZERO_CHAR = DEFAULT_ZERO_CHAR
) (
  input  logic                clk_48mhz,
  input  logic                reset,
  uart_bitvec_bridge_if.slave bus,
  output logic [IN_LEN-1:0]   in_vec,
  input  logic [OUT_LEN-1:0]  out_vec,
  output logic                rx_seen,
  output logic                rx_err,
  output logic [15:0]         frame_count
);

  logic              rx_ready_q, rx_ready_d;
  logic [IN_LEN-1:0] in_vec_q, in_vec_d;
  logic              rx_seen_q, rx_seen_d;
  logic              rx_err_q, rx_err_d;
  logic [6:0]        addr;
  logic              val;
  logic              rx_xfer;
  logic              in_range;

  assign addr     = bus.rx_data[7:1];
  assign val      = bus.rx_data[0];
  assign rx_xfer  = bus.rx_valid && rx_ready_q;
  assign in_range = ({25'd0, addr} < 32'(IN_LEN));

  always_comb begin
    rx_ready_d = 1'b1;
    in_vec_d   = in_vec_q;
    rx_seen_d  = rx_seen_q;
    rx_err_d   = rx_err_q;
    if (rx_xfer) begin
      if (in_range) begin
        for (int i = 0; i < IN_LEN; i++) begin
          if (addr == 7'(i)) in_vec_d[i] = val;
        end
        rx_seen_d = 1'b1;
      end else begin
        rx_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      rx_ready_q <= 1'b0;
      in_vec_q   <= '0;
      rx_seen_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_d;
      in_vec_q   <= in_vec_d;
      rx_seen_q  <= rx_seen_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign in_vec       = in_vec_q;
  assign rx_seen      = rx_seen_q;
  assign rx_err       = rx_err_q;

  bitvec_tx_serializer #(
    .OUT_LEN   (OUT_LEN),
    .TERM_CHAR (TERM_CHAR),
    .ZERO_CHAR (ZERO_CHAR)
  ) u_tx (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .out_vec     (out_vec),
    .tx_ready    (bus.tx_ready),
    .tx_valid    (bus.tx_valid),
    .tx_data     (bus.tx_data),
    .frame_count (frame_count)
  );

endmodule
